// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - radix-2 multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic             FLUSH,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] RESULT
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   acc;
    logic             neg_q;
    logic             neg_r;
    logic [CW-1:0]    cnt;

    // Operand decode at the START edge
    logic             is_div;
    logic             a_sgn;
    logic             b_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        is_div   = SELECT[2];
        a_sgn    = is_div ? ~SELECT[0] : (SELECT == 3'b001 || SELECT == 3'b010);
        b_sgn    = is_div ? ~SELECT[0] : (SELECT == 3'b001);
        a_neg    = a_sgn & DATA1[WIDTH-1];
        b_neg    = b_sgn & DATA2[WIDTH-1];
        a_mag_in = a_neg ? -DATA1 : DATA1;
        b_mag_in = b_neg ? -DATA2 : DATA2;
        div_zero = is_div && (DATA2 == '0);
        div_ovf  = is_div && !SELECT[0] && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}})
                   && (DATA2 == '1);
        if (div_zero)
            special_res = SELECT[1] ? DATA1 : '1;
        else
            special_res = SELECT[1] ? '0 : DATA1;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [WIDTH:0]     fast_a;
    logic signed [WIDTH:0]     fast_b;
    logic signed [2*WIDTH-1:0] fast_p;
    logic        [WIDTH-1:0]   fast_res;

    always_comb begin
        fast_a   = $signed({a_sgn & DATA1[WIDTH-1], DATA1});
        fast_b   = $signed({b_sgn & DATA2[WIDTH-1], DATA2});
        fast_p   = (2*WIDTH)'(fast_a) * (2*WIDTH)'(fast_b);
        fast_res = (SELECT == 3'b000) ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH];
    end
`endif

    // One iteration step: shift-add for multiply, restoring subtract for divide
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] full;
    logic [2*WIDTH-1:0] full_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        mul_sum  = q_reg[0] ? (acc + {1'b0, b_mag}) : acc;
        div_sh   = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_mag};
        full     = {acc[WIDTH-1:0], q_reg};
        full_s   = neg_q ? -full : full;
        quo      = neg_q ? -q_reg : q_reg;
        rem      = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        case (op_sel)
            3'b000:                 fin_res = full_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fin_res = full_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fin_res = quo;
            default:                fin_res = rem;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state  <= IDLE;
            BUSY   <= 1'b0;
            VALID  <= 1'b0;
            RESULT <= '0;
            op_sel <= '0;
            b_mag  <= '0;
            q_reg  <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
        end else if (FLUSH) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            VALID <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    VALID <= 1'b0;
                    if (START) begin
                        op_sel <= SELECT;
                        acc    <= '0;
                        cnt    <= '0;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        BUSY   <= 1'b1;
                        // Multiply keeps the multiplier in q_reg, divide the dividend
                        q_reg  <= is_div ? a_mag_in : b_mag_in;
                        b_mag  <= is_div ? b_mag_in : a_mag_in;
                        if (div_zero || div_ovf) begin
                            RESULT <= special_res;
                            VALID  <= 1'b1;
                            state  <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            RESULT <= fast_res;
                            VALID  <= 1'b1;
                            state  <= DONE;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // The extra cycle after the last iteration applies the sign fixup
                    if (cnt == CW'(WIDTH)) begin
                        RESULT <= fin_res;
                        VALID  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (op_sel[2]) begin
                            if (!div_diff[WIDTH]) begin
                                acc   <= div_diff;
                                q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                            end else begin
                                acc   <= div_sh;
                                q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            {acc, q_reg} <= {1'b0, mul_sum, q_reg[WIDTH-1:1]};
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    VALID <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - vector table, random ops against an arithmetic model, flush and reset sequences
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_EDGES = 0;
`else
    localparam int MUL_EDGES = 33;
`endif

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        START = 1'b0;
    logic        FLUSH = 1'b0;
    logic [2:0]  SELECT = '0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        BUSY;
    logic        VALID;
    logic [31:0] RESULT;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_exp = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .FLUSH(FLUSH),
        .SELECT(SELECT), .DATA1(DATA1), .DATA2(DATA2),
        .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       nm;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          edges;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        case (s)
            3'd0: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); pu = p; return pu[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'd0, b}); pu = p; return pu[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        if (!s[2]) return MUL_EDGES;
        if (b == 0) return 0;
        if (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    // Edge count is measured from the edge that samples START to the edge after which VALID is seen.
    task automatic run_op(input string nm, input logic [2:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_edges);
        int e;
        bit seen;
        bit busy_ok;
        SELECT = s; DATA1 = a; DATA2 = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        SELECT = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom;
        e = 0; seen = 0; busy_ok = 1;
        while (e <= 40) begin
            if (!BUSY) busy_ok = 0;
            if (VALID) begin seen = 1; break; end
            START = (e == 5);
            @(posedge CLK); #1;
            e++;
        end
        START = 1'b0;
        check({nm, " latency"}, seen ? e : -1, exp_edges);
        check({nm, " result"}, RESULT, exp_res);
        check({nm, " busy"}, busy_ok, 1'b1);
        @(posedge CLK); #1;
        check({nm, " pulse end"}, {VALID, BUSY}, 2'b00);
        last_exp = exp_res;
    endtask

    initial begin
        bit no_valid;
        logic [2:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;

        vecs[0]  = '{"mul",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_EDGES};
        vecs[1]  = '{"mulh",       3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_EDGES};
        vecs[2]  = '{"mulhu",      3'd3, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006, MUL_EDGES};
        vecs[3]  = '{"mulhsu",     3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_EDGES};
        vecs[4]  = '{"div",        3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33};
        vecs[5]  = '{"rem",        3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33};
        vecs[6]  = '{"divu0",      3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 0};
        vecs[7]  = '{"remu0",      3'd7, 32'd100,        32'd0,         32'h0000_0064, 0};
        vecs[8]  = '{"div ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0};
        vecs[9]  = '{"rem ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 0};
        vecs[10] = '{"div0",       3'd4, 32'd7,          32'd0,         32'hFFFF_FFFF, 0};
        vecs[11] = '{"rem0",       3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 0};
        vecs[12] = '{"divu max",   3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33};
        vecs[13] = '{"div negb",   3'd4, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 33};
        vecs[14] = '{"rem negb",   3'd6, 32'd20,         32'hFFFF_FFFD, 32'h0000_0002, 33};

        #2;
        check("reset busy", BUSY, 1'b0);
        check("reset valid", VALID, 1'b0);
        check("reset result", RESULT, 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;

        for (int i = 0; i < 15; i++)
            run_op(vecs[i].nm, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].edges);

        for (int i = 0; i < 60; i++) begin
            s = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15)) - 32'd8;
            if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            r = ref_op(s, a, b);
            run_op($sformatf("rand%0d sel%0d", i, s), s, a, b, r, exp_lat(s, a, b));
        end

        // Flush mid-division, with a START pulse ignored while busy
        SELECT = 3'd5; DATA1 = 32'd50; DATA2 = 32'd5; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        no_valid = 1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) begin START = 1'b1; DATA1 = 32'd1000; DATA2 = 32'd7; end
            else START = 1'b0;
            FLUSH = (c == 10);
            @(posedge CLK); #1;
            if (VALID) no_valid = 0;
        end
        FLUSH = 1'b0; START = 1'b0;
        check("flush no valid", no_valid, 1'b1);
        check("flush busy", BUSY, 1'b0);
        check("flush result hold", RESULT, last_exp);

        SELECT = 3'd0; DATA1 = 32'd3; DATA2 = 32'd4; START = 1'b1; FLUSH = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; FLUSH = 1'b0;
        check("flush beats start", BUSY, 1'b0);
        run_op("after flush", 3'd5, 32'd50, 32'd5, 32'd10, 33);

        // Reset in the middle of a multiply
        SELECT = 3'd0; DATA1 = 32'd123; DATA2 = 32'd456; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b0;
        #1;
        check("async rst busy", BUSY, 1'b0);
        check("async rst valid", VALID, 1'b0);
        check("async rst result", RESULT, 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;
        no_valid = 1;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (VALID || BUSY) no_valid = 0;
        end
        check("no valid after reset", no_valid, 1'b1);
        run_op("post reset mul", 3'd0, 32'd123, 32'd456, 32'd56088, MUL_EDGES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RESETN  input  1  asynchronous active-low reset.
REQ-004 SHALL have port START  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port FLUSH  input  1  synchronous abort of the operation in flight.
REQ-006 SHALL have port SELECT  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port DATA1  input  WIDTH  operand A (dividend/multiplicand).
REQ-008 SHALL have port DATA2  input  WIDTH  operand B (divisor/multiplier).
REQ-009 SHALL have port BUSY  output  1  high while an operation is in flight.
REQ-010 SHALL have port VALID  output  1  one-cycle pulse when RESULT is new.
REQ-011 SHALL have port RESULT  output  WIDTH  registered result.

Function
REQ-012 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-013 SHALL, in IDLE with START=1 and FLUSH=0, register SELECT, DATA1 and DATA2 at that edge, set BUSY=1 and enter CALC.
REQ-014 SHALL perform one radix-2 iteration per CALC cycle, WIDTH iterations total, then enter DONE.
- MUL family: shift-add over a 2*WIDTH product.
- DIV family: restoring division on operand magnitudes.
REQ-015 SHALL, in DONE, drive VALID=1 and BUSY=1 for exactly one cycle, then return to IDLE.
REQ-016 SHALL give a normal latency of WIDTH+1 cycles: START sampled at edge k, VALID high during the cycle after edge k+WIDTH+1.
REQ-017 SHALL return for MUL the low WIDTH bits of the product, and for MULH, MULHSU and MULHU the high WIDTH bits of signed*signed, signed*unsigned and unsigned*unsigned respectively.
REQ-018 SHALL make DIV and REM truncate toward zero, with the remainder taking the sign of the dividend.
REQ-019 SHALL, on divide by zero, return DIV/DIVU all-ones and REM/REMU equal to DATA1.
REQ-020 SHALL, on signed overflow (DATA1 = most-negative, DATA2 = all-ones), return DIV = DATA1 and REM = 0.
REQ-021 SHALL send the REQ-019/020 cases from IDLE directly to DONE, bypassing CALC (latency 1).
REQ-022 SHALL ignore START while BUSY=1: no requeue and no effect on the operation in flight.
REQ-023 SHALL make FLUSH=1 in any state force IDLE at the next edge, with no VALID pulse and RESULT unchanged; FLUSH takes priority over START in the same cycle.
REQ-024 SHALL update RESULT only on entry to DONE and hold it until the next DONE.
REQ-025 SHALL allow a new START in the cycle immediately after DONE (back-to-back, no dead cycle beyond DONE).

Reset
REQ-026 SHALL, while RESETN=0, asynchronously force state IDLE, BUSY=0, VALID=0, RESULT=0 and clear the iteration counter and operand registers.
REQ-027 SHALL make reset asserted mid-operation discard that operation, with no VALID after release.
REQ-028 SHALL sample the first START at the first rising edge with RESETN=1.

Configuration
REQ-029 SHALL, with macro MULDIV_FAST_MUL_EN defined, compute MUL/MULH/MULHSU/MULHU with a single-cycle multiplier: IDLE goes to DONE directly (latency 1), while the DIV family is unchanged.
REQ-030 SHALL, without MULDIV_FAST_MUL_EN, compute all multiplies iteratively per REQ-014 (latency WIDTH+1) with no hardware multiplier inferred.

Verification (WIDTH=32)
REQ-031 SHALL cover: MUL/MULH/MULHU with DATA1=7, DATA2=0xFFFFFFFD -> RESULT 0xFFFFFFEB / 0xFFFFFFFF / 0x00000006; VALID 33 cycles after START (1 cycle with MULDIV_FAST_MUL_EN).
REQ-032 SHALL cover: DIV and REM with DATA1=0xFFFFFFEC (-20), DATA2=3 -> 0xFFFFFFFA and 0xFFFFFFFE; VALID 33 cycles after START.
REQ-033 SHALL cover: DIVU and REMU with DATA1=100, DATA2=0 -> 0xFFFFFFFF and 0x00000064; VALID 1 cycle after START.
REQ-034 SHALL cover: DIV and REM with DATA1=0x80000000, DATA2=0xFFFFFFFF -> 0x80000000 and 0x00000000; latency 1.
REQ-035 SHALL cover: DIVU 50/5 started, START pulsed at cycle 3, FLUSH at cycle 10 -> no VALID, RESULT holds its prior value, BUSY=0 from cycle 11; a new START at cycle 11 completes normally.
REQ-036 SHALL cover: RESETN low at cycle 5 of a MUL -> BUSY/VALID/RESULT = 0 immediately (asynchronously); no VALID after release.
